// File: rtl/fir_pkg.sv
// Shared FIR constants and saturation bounds.
package fir_pkg;
    localparam int IW_DEF    = 16;
    localparam int TW_DEF    = 16;
    localparam int OW_DEF    = 40;
    localparam int SHIFT_DEF = 15;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO for the drain; occupancy counter separates full from empty.
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign o_full  = (level_q == LW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    // Full still accepts a push when a pop frees a slot on the same edge.
    assign do_push = i_push && (!o_full || i_pop);
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : mem[rd_q];

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) level_d = level_q + LW'(1);
        else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_q] <= i_wdata;
    end
endmodule

// File: rtl/fir_out_drain.sv
// Rounds, saturates and buffers the tap-chain accumulator; never back-pressures.
module fir_out_drain
    import fir_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_ce,
    input  logic signed [OW-1:0]        i_acc,
    input  logic                        i_clr,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [IW-1:0]        o_data,
    output logic                        o_sat,
    output logic                        o_overrun,
    output logic [$clog2(DEPTH):0]      o_level
);
    localparam int RW = OW + 1 - SHIFT;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic signed [RW-1:0] SMAX = RW'(sat_max(IW));
    localparam logic signed [RW-1:0] SMIN = RW'(sat_min(IW));
    localparam logic signed [OW:0]   HALF = (OW + 1)'(1) <<< (SHIFT - 1);

    logic signed [OW:0]   sum;
    logic signed [RW-1:0] r_q;
    logic signed [IW-1:0] s2_q, s2_d;
    logic                 s1_valid_q, s2_valid_q;
    logic                 clamp_hi, clamp_lo;
    logic                 sat_q, sat_d, ovr_q, ovr_d;
    logic                 full, empty, pop;
    logic [IW-1:0]        rdata;
    logic [LW-1:0]        level;

    // One extra bit keeps the rounding add from wrapping; the slice is the >>>.
    assign sum = {i_acc[OW-1], i_acc} + HALF;

    always_comb begin
        clamp_hi = (r_q > SMAX);
        clamp_lo = (r_q < SMIN);
        s2_d     = clamp_hi ? IW'(SMAX) : (clamp_lo ? IW'(SMIN) : IW'(r_q));
    end

    assign pop   = o_valid && i_ready;
    assign sat_d = (i_clr ? 1'b0 : sat_q) | (s1_valid_q & (clamp_hi | clamp_lo));
    assign ovr_d = (i_clr ? 1'b0 : ovr_q) | (s2_valid_q & full & ~pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q        <= '0;
            s2_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (i_ce)       r_q  <= sum[OW:SHIFT];
            if (s1_valid_q) s2_q <= s2_d;
            s1_valid_q <= i_ce;
            s2_valid_q <= s1_valid_q;
            sat_q      <= sat_d;
            ovr_q      <= ovr_d;
        end
    end

    fir_out_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (s2_valid_q),
        .i_wdata (s2_q),
        .i_pop   (pop),
        .o_rdata (rdata),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level)
    );

    assign o_valid   = !empty;
    assign o_data    = $signed(rdata);
    assign o_level   = level;
    assign o_sat     = sat_q;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_fir_out_drain.sv
// Directed checks of rounding, saturation, FIFO ordering, overrun and reset.
module tb_fir_out_drain;
    logic               i_clk = 1'b0;
    logic               i_reset, i_ce, i_clr, i_ready;
    logic signed [39:0] i_acc;
    logic               o_valid, o_sat, o_overrun;
    logic signed [15:0] o_data;
    logic [2:0]         o_level;
    int errors = 0;
    int checks = 0;

    fir_out_drain #(.IW(16), .OW(40), .SHIFT(15), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_acc(i_acc), .i_clr(i_clr),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat),
        .o_overrun(o_overrun), .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_ce = 1'b0; i_clr = 1'b0; i_ready = 1'b0; i_acc = '0;
        tick(); tick();
        checks++; if ({o_valid, o_sat, o_overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {o_valid, o_sat, o_overrun}); end
        checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", o_level); end
        checks++; if (o_data !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d want=0", o_data); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_rounding();
        logic signed [39:0] acc [4];
        logic signed [15:0] exp [4];
        acc = '{40'sd98304, 40'sd16384, 40'sd16383, -40'sd16384};
        exp = '{16'sd3, 16'sd1, 16'sd0, 16'sd0};
        i_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            i_ce  = (c < 4);
            i_acc = (c < 4) ? acc[c] : '0;
            tick();
            if (c == 1) begin
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL round_latency got=%b want=0", o_valid); end
            end
            if (c >= 2 && c < 6) begin
                checks++; if (o_valid !== 1'b1 || o_data !== exp[c-2]) begin errors++; $display("FAIL round_data%0d got=%0d/%b want=%0d/1", c-2, o_data, o_valid, exp[c-2]); end
            end
        end
        checks++; if (o_sat !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL round_nosat got=%b%b want=00", o_sat, o_valid); end
    endtask

    task automatic test_saturation();
        i_ready = 1'b1;
        i_ce = 1'b1; i_acc = 40'sd2147483648; tick();
        i_acc = -40'sd2147483648; tick();
        i_ce = 1'b0; i_acc = '0; tick();
        checks++; if (o_data !== 16'sd32767) begin errors++; $display("FAIL sat_pos got=%0d want=32767", o_data); end
        checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b want=1", o_sat); end
        tick();
        checks++; if (o_data !== -16'sd32768) begin errors++; $display("FAIL sat_neg got=%0d want=-32768", o_data); end
        tick();
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL sat_clr got=%b want=0", o_sat); end
        // Clear coinciding with a clamp: set wins.
        i_ce = 1'b1; i_acc = 40'sd2147483648; tick();
        i_ce = 1'b0; i_clr = 1'b1; tick(); i_clr = 1'b0;
        checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_setwins got=%b want=1", o_sat); end
        tick(); tick();
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        checks++; if (o_sat !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL sat_clr2 got=%b%b want=00", o_sat, o_valid); end
    endtask

    task automatic test_overrun();
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            i_ce = 1'b1; i_acc = 40'(k * 32768); tick();
        end
        i_ce = 1'b0; i_acc = '0;
        tick(); tick(); tick();
        checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL ovr_level got=%0d want=4", o_level); end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b want=1", o_overrun); end
        checks++; if (o_data !== 16'sd1) begin errors++; $display("FAIL ovr_hold got=%0d want=1", o_data); end
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(k)) begin errors++; $display("FAIL ovr_order%0d got=%0d/%b want=%0d/1", k, o_data, o_valid, k); end
            tick();
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop got=%b data=%0d want=0", o_valid, o_data); end
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b want=0", o_overrun); end
    endtask

    task automatic test_full_pushpop();
        i_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            i_ce = 1'b1; i_acc = 40'(k * 32768); tick();
        end
        i_ce = 1'b0; tick(); tick();
        checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL pp_full got=%0d want=4", o_level); end
        i_ce = 1'b1; i_acc = 40'(14 * 32768); tick();
        i_ce = 1'b0; tick();
        i_ready = 1'b1; tick();
        i_ready = 1'b0;
        checks++; if (o_level !== 3'd4 || o_overrun !== 1'b0) begin errors++; $display("FAIL pp_level got=%0d ovr=%b want=4 ovr=0", o_level, o_overrun); end
        checks++; if (o_data !== 16'sd11) begin errors++; $display("FAIL pp_head got=%0d want=11", o_data); end
        i_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== 16'(k)) begin errors++; $display("FAIL pp_order%0d got=%0d/%b want=%0d/1", k, o_data, o_valid, k); end
            tick();
        end
        checks++; if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin errors++; $display("FAIL pp_end got=%b%b want=00", o_valid, o_overrun); end
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0;
        for (int k = 20; k <= 23; k++) begin
            i_ce = 1'b1; i_acc = 40'(k * 32768); tick();
        end
        i_ce = 1'b0; tick();
        checks++; if (o_level !== 3'd3 || o_data !== 16'sd20) begin errors++; $display("FAIL rst_pre got=%0d/%0d want=3/20", o_level, o_data); end
        i_reset = 1'b1; #1;
        checks++; if ({o_valid, o_sat, o_overrun} !== 3'b000 || o_level !== 3'd0 || o_data !== 16'sd0) begin errors++; $display("FAIL rst_async got=%b%b%b lvl=%0d d=%0d want=000 lvl=0 d=0", o_valid, o_sat, o_overrun, o_level, o_data); end
        tick();
        i_reset = 1'b0;
        i_ce = 1'b1; i_acc = 40'(7 * 32768); tick();
        i_ce = 1'b0; i_acc = '0; tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_latency got=%b want=0", o_valid); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd7 || o_level !== 3'd1) begin errors++; $display("FAIL rst_new got=%0d lvl=%0d want=7 lvl=1", o_data, o_level); end
        tick(); tick();
        checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL rst_alone got=%0d want=1", o_level); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_overrun();
        test_full_pushpop();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
